// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: frame tick, serve/play/pause/point/over FSM, score, lives and speed level.
// Button presses are synchronised and edge-detected. Ball/paddle datapaths are gated through single-cycle enables.
module pong_match_ctrl #(
  parameter int TICK_DIV     = 85875,
  parameter int SERVE_TICKS  = 200,
  parameter int POINT_TICKS  = 100,
  parameter int LIVES        = 3,
  parameter int SPEEDUP_HITS = 5,
  parameter int MAX_LEVEL    = 3,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_n,
  input  logic               pause_n,
  input  logic               ball_hit,
  input  logic               ball_miss,
  output logic               tick,
  output logic               ball_step,
  output logic               paddle_en,
  output logic               ball_load,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [1:0]         level,
  output logic [2:0]         state,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SERVE  = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_PAUSED = 3'd3;
  localparam logic [2:0] S_POINT  = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WAIT_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int HIT_W    = $clog2(SPEEDUP_HITS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [WAIT_W-1:0] SERVE_LAST = WAIT_W'(SERVE_TICKS - 1);
  localparam logic [WAIT_W-1:0] POINT_LAST = WAIT_W'(POINT_TICKS - 1);
  localparam logic [HIT_W-1:0]  HITS_LAST  = HIT_W'(SPEEDUP_HITS - 1);
  localparam logic [1:0]        MAXL       = 2'(MAX_LEVEL);
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);

  logic [DIV_W-1:0]   r_div;
  logic [WAIT_W-1:0]  r_wait;
  logic [HIT_W-1:0]   r_hit_cnt;
  logic [1:0]         r_step_cnt;
  logic [1:0]         r_level;
  logic [2:0]         r_state;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_start_q;
  logic [2:0]         r_pause_q;
  logic               r_load;
  logic               r_step;

  logic w_tick;
  logic w_start;
  logic w_pause;
  logic w_step_due;

  assign w_tick  = (r_div == DIV_LAST);
  // [1:0] is the two-flop synchroniser, [2] holds the previous synchronised value for edge detect
  assign w_start = r_start_q[2] & ~r_start_q[1];
  assign w_pause = r_pause_q[2] & ~r_pause_q[1];
  // >= keeps the step cadence sane when a level-up lowers the target below the running count
  assign w_step_due = (r_step_cnt >= (MAXL - r_level));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_wait     <= '0;
      r_hit_cnt  <= '0;
      r_step_cnt <= '0;
      r_level    <= '0;
      r_state    <= S_IDLE;
      r_lives    <= LIVES_INIT;
      r_score    <= '0;
      r_start_q  <= '1;
      r_pause_q  <= '1;
      r_load     <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      r_start_q <= {r_start_q[1:0], start_n};
      r_pause_q <= {r_pause_q[1:0], pause_n};
      r_load    <= 1'b0;
      r_step    <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start) begin
            r_state   <= S_SERVE;
            r_wait    <= '0;
            r_load    <= 1'b1;
            r_score   <= '0;
            r_lives   <= LIVES_INIT;
            r_level   <= '0;
            r_hit_cnt <= '0;
          end
        end
        S_SERVE: begin
          if (w_tick) begin
            if (r_wait == SERVE_LAST) begin
              r_state    <= S_PLAY;
              r_wait     <= '0;
              r_step_cnt <= '0;
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
        end
        S_PLAY: begin
          // a miss pre-empts any hit or pause arriving in the same cycle
          if (ball_miss) begin
            r_lives <= r_lives - 3'd1;
            r_state <= S_POINT;
            r_wait  <= '0;
          end else begin
            if (w_pause) begin
              r_state <= S_PAUSED;
              r_wait  <= '0;
            end else if (w_tick) begin
              if (w_step_due) begin
                r_step     <= 1'b1;
                r_step_cnt <= '0;
              end else begin
                r_step_cnt <= r_step_cnt + 2'd1;
              end
            end
            if (ball_hit) begin
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
              if (r_hit_cnt == HITS_LAST) begin
                r_hit_cnt <= '0;
                if (r_level != MAXL) r_level <= r_level + 2'd1;
              end else begin
                r_hit_cnt <= r_hit_cnt + HIT_W'(1);
              end
            end
          end
        end
        S_PAUSED: begin
          if (w_pause) begin
            r_state <= S_PLAY;
            r_wait  <= '0;
          end
        end
        S_POINT: begin
          if (w_tick) begin
            if (r_wait == POINT_LAST) begin
              r_wait <= '0;
              if (r_lives == 3'd0) begin
                r_state <= S_OVER;
              end else begin
                r_state   <= S_SERVE;
                r_load    <= 1'b1;
                r_level   <= '0;
                r_hit_cnt <= '0;
              end
            end else begin
              r_wait <= r_wait + WAIT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tick      = w_tick;
  assign ball_step = r_step;
  assign ball_load = r_load;
  assign paddle_en = (r_state == S_SERVE) || (r_state == S_PLAY);
  assign game_over = (r_state == S_OVER);
  assign score     = r_score;
  assign lives     = r_lives;
  assign level     = r_level;
  assign state     = r_state;

endmodule
